// File: rtl/param_hash.sv
// param_hash: FNV-1a digest over a four-phase F_dr/F_rtr byte stream.
// Optional Byte_cnt output when PARAM_HASH_BYTECNT_EN is defined.
module param_hash #(
   parameter int HASH_W     = 32,
   parameter int BEAT_BYTES = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic [8*BEAT_BYTES-1:0]          Byte,
   input  logic [$clog2(BEAT_BYTES+1)-1:0]  Byte_num,
   input  logic                             End_of_File,
   input  logic                             F_dr,
   output logic [0:HASH_W-1]                R_h,
   output logic                             F_rtr,
   output logic                             H_ready
`ifdef PARAM_HASH_BYTECNT_EN
   ,
   output logic [31:0]                      Byte_cnt
`endif
);

   localparam int NW = $clog2(BEAT_BYTES+1);

   localparam logic [63:0] INIT64 = (HASH_W == 64) ?
      64'hCBF29CE484222325 : 64'h0000_0000_811C9DC5;
   localparam logic [63:0] PRIME64 = (HASH_W == 64) ?
      64'h00000100000001B3 : 64'h0000_0000_01000193;

   localparam logic [HASH_W-1:0] INIT  = INIT64[HASH_W-1:0];
   localparam logic [HASH_W-1:0] PRIME = PRIME64[HASH_W-1:0];

   if (HASH_W != 32 && HASH_W != 64) begin : g_bad_hash_w
      $error("param_hash: HASH_W must be 32 or 64");
   end

   if (BEAT_BYTES != 1 && BEAT_BYTES != 2 &&
       BEAT_BYTES != 4 && BEAT_BYTES != 8) begin : g_bad_beat
      $error("param_hash: BEAT_BYTES must be 1, 2, 4 or 8");
   end

   typedef enum logic [2:0] {
      IDLE, WAIT_REQ, PROC, WAIT_REL, FINAL
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [HASH_W-1:0]       h;
   logic [HASH_W-1:0]       h_mix;
   logic [8*BEAT_BYTES-1:0] beat_q;
   logic [NW-1:0]           k_q;
   logic [NW-1:0]           k_in;
   logic [NW-1:0]           lane_q;
   logic                    last_q;
   logic                    proc_done;
   logic [7:0]              lane_byte;

   // Clamp the lane count, pick the current lane and fold it into h.
   always_comb begin
      k_in = (Byte_num > NW'(BEAT_BYTES)) ? NW'(BEAT_BYTES) : Byte_num;
      lane_byte = 8'(beat_q >> {lane_q, 3'b000});
      h_mix = (h ^ {{(HASH_W-8){1'b0}}, lane_byte}) * PRIME;
      proc_done = (k_q == '0) || (lane_q == k_q - NW'(1));
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; an empty beat still spends one cycle in PROC.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (start) state_nxt = WAIT_REQ;
         WAIT_REQ: begin
            if (F_dr) begin
               state_nxt = PROC;
            end else if (End_of_File) begin
               state_nxt = FINAL;
            end
         end
         PROC:     if (proc_done) state_nxt = last_q ? FINAL : WAIT_REL;
         WAIT_REL: if (!F_dr) state_nxt = WAIT_REQ;
         FINAL:    state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Handshake acknowledge is high only while waiting for a request.
   always_comb begin
      F_rtr = (state == WAIT_REQ);
   end

   // Datapath: running hash, latched beat, lane counter and result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h       <= '0;
         beat_q  <= '0;
         k_q     <= '0;
         lane_q  <= '0;
         last_q  <= 1'b0;
         R_h     <= '0;
         H_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  h       <= INIT;
                  lane_q  <= '0;
                  H_ready <= 1'b0;
               end
            end
            WAIT_REQ: begin
               if (F_dr) begin
                  beat_q <= Byte;
                  k_q    <= k_in;
                  last_q <= End_of_File;
                  lane_q <= '0;
               end
            end
            PROC: begin
               if (k_q != '0) begin
                  h      <= h_mix;
                  lane_q <= lane_q + NW'(1);
               end
            end
            FINAL: begin
               R_h     <= h;
               H_ready <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef PARAM_HASH_BYTECNT_EN
   // Saturating count of hashed lanes, cleared on an accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Byte_cnt <= '0;
      end else if (state == IDLE && start) begin
         Byte_cnt <= '0;
      end else if (state == PROC && k_q != '0 && Byte_cnt != '1) begin
         Byte_cnt <= Byte_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_param_hash.sv
// Bench for param_hash: three instances (32/1, 32/4, 64/1) driven by
// table vectors, hand sequences and random messages against a model.
module tb_param_hash;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   logic        s0, d0, e0, t0, y0;
   logic [7:0]  b0;
   logic [0:0]  n0;
   logic [0:31] r0;
   logic        s1, d1, e1, t1, y1;
   logic [31:0] b1;
   logic [2:0]  n1;
   logic [0:31] r1;
   logic        s2, d2, e2, t2, y2;
   logic [7:0]  b2;
   logic [0:0]  n2;
   logic [0:63] r2;
`ifdef PARAM_HASH_BYTECNT_EN
   logic [31:0] c0, c1, c2;
`endif

   param_hash #(.HASH_W(32), .BEAT_BYTES(1)) u0 (
      .clk(clk), .rst_n(rst_n), .start(s0), .Byte(b0), .Byte_num(n0),
      .End_of_File(e0), .F_dr(d0), .R_h(r0), .F_rtr(t0), .H_ready(y0)
`ifdef PARAM_HASH_BYTECNT_EN
      , .Byte_cnt(c0)
`endif
   );

   param_hash #(.HASH_W(32), .BEAT_BYTES(4)) u1 (
      .clk(clk), .rst_n(rst_n), .start(s1), .Byte(b1), .Byte_num(n1),
      .End_of_File(e1), .F_dr(d1), .R_h(r1), .F_rtr(t1), .H_ready(y1)
`ifdef PARAM_HASH_BYTECNT_EN
      , .Byte_cnt(c1)
`endif
   );

   param_hash #(.HASH_W(64), .BEAT_BYTES(1)) u2 (
      .clk(clk), .rst_n(rst_n), .start(s2), .Byte(b2), .Byte_num(n2),
      .End_of_File(e2), .F_dr(d2), .R_h(r2), .F_rtr(t2), .H_ready(y2)
`ifdef PARAM_HASH_BYTECNT_EN
      , .Byte_cnt(c2)
`endif
   );

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      int          sel;
      string       msg;
      bit          eof_last;
      logic [63:0] exp;
   } vec_t;

   function automatic int bb(int sel);
      return (sel == 1) ? 4 : 1;
   endfunction

   function automatic int hw(int sel);
      return (sel == 2) ? 64 : 32;
   endfunction

   function automatic logic get_rtr(int sel);
      case (sel)
         0: return t0;
         1: return t1;
         default: return t2;
      endcase
   endfunction

   function automatic logic get_rdy(int sel);
      case (sel)
         0: return y0;
         1: return y1;
         default: return y2;
      endcase
   endfunction

   function automatic logic [63:0] get_rh(int sel);
      case (sel)
         0: return {32'h0, r0};
         1: return {32'h0, r1};
         default: return r2;
      endcase
   endfunction

`ifdef PARAM_HASH_BYTECNT_EN
   function automatic logic [31:0] get_cnt(int sel);
      case (sel)
         0: return c0;
         1: return c1;
         default: return c2;
      endcase
   endfunction
`endif

   // FNV-1a straight from its definition, masked to the digest width.
   function automatic logic [63:0] ref_hash(int w, logic [7:0] q[$]);
      logic [63:0] h, p, m;
      h = (w == 64) ? 64'hCBF29CE484222325 : 64'h811C9DC5;
      p = (w == 64) ? 64'h00000100000001B3 : 64'h01000193;
      m = (w == 64) ? 64'hFFFFFFFFFFFFFFFF : 64'hFFFFFFFF;
      foreach (q[i]) h = ((h ^ {56'h0, q[i]}) * p) & m;
      return h;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(int sel, logic st, logic dr, logic eof,
                        logic [63:0] data, logic [3:0] num);
      case (sel)
         0: begin
            s0 = st; d0 = dr; e0 = eof; b0 = data[7:0]; n0 = num[0:0];
         end
         1: begin
            s1 = st; d1 = dr; e1 = eof; b1 = data[31:0]; n1 = num[2:0];
         end
         default: begin
            s2 = st; d2 = dr; e2 = eof; b2 = data[7:0]; n2 = num[0:0];
         end
      endcase
   endtask

   task automatic wait_rtr(int sel);
      int n = 0;
      while (get_rtr(sel) !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) check("rtr_timeout", {63'h0, get_rtr(sel)}, 64'h1);
   endtask

   task automatic begin_msg(int sel);
      @(negedge clk);
      drive(sel, 1'b1, 1'b0, 1'b0, 64'h0, 4'h0);
      @(negedge clk);
      drive(sel, 1'b0, 1'b0, 1'b0, 64'h0, 4'h0);
      check("start_rtr", {63'h0, get_rtr(sel)}, 64'h1);
      check("start_hrdy", {63'h0, get_rdy(sel)}, 64'h0);
   endtask

   task automatic beat(int sel, logic [63:0] data, int numf, bit eof);
      int n, k, lat;
      wait_rtr(sel);
      drive(sel, 1'b0, 1'b1, eof, data, 4'(numf));
      @(negedge clk);
      drive(sel, 1'b0, 1'b0, 1'b0, data, 4'(numf));
      check("accept_rtr", {63'h0, get_rtr(sel)}, 64'h0);
      k = (numf > bb(sel)) ? bb(sel) : numf;
      lat = ((k > 1) ? k : 1) + 2;
      n = 1;
      while (n < 50 && (eof ? get_rdy(sel) !== 1'b1
                            : get_rtr(sel) !== 1'b1)) begin
         @(negedge clk);
         n++;
      end
      check(eof ? "eof_beat_lat" : "beat_lat", 64'(n), 64'(lat));
   endtask

   task automatic end_eof(int sel);
      wait_rtr(sel);
      drive(sel, 1'b0, 1'b0, 1'b1, 64'h0, 4'h0);
      @(negedge clk);
      drive(sel, 1'b0, 1'b0, 1'b0, 64'h0, 4'h0);
      check("eof_rtr", {63'h0, get_rtr(sel)}, 64'h0);
      check("eof_hrdy_early", {63'h0, get_rdy(sel)}, 64'h0);
      @(negedge clk);
      check("eof_hrdy", {63'h0, get_rdy(sel)}, 64'h1);
   endtask

   task automatic run_msg(int sel, logic [7:0] q[$], bit eof_last, bit rnd);
      int idx, n, rem, numf;
      logic [63:0] data;
      bit eof;
      begin_msg(sel);
      idx = 0;
      while (idx < q.size()) begin
         rem = q.size() - idx;
         n = (rem < bb(sel)) ? rem : bb(sel);
         if (rnd) n = $urandom_range(0, n);
         numf = n;
         if (rnd && n == 4 && $urandom_range(0, 1) == 1)
            numf = $urandom_range(5, 7);
         data = {$urandom, $urandom};
         for (int j = 0; j < n; j++) data[8*j +: 8] = q[idx+j];
         idx += n;
         eof = eof_last && idx == q.size() && n > 0;
         beat(sel, data, numf, eof);
      end
      if (!(eof_last && q.size() > 0)) end_eof(sel);
   endtask

   task automatic check_cnt(int sel, int nbytes);
`ifdef PARAM_HASH_BYTECNT_EN
      check("byte_cnt", {32'h0, get_cnt(sel)}, 64'(nbytes));
`else
      if (nbytes < 0) check("byte_cnt", 64'(nbytes), 64'h0);
`endif
   endtask

   function automatic void str2q(string s, ref logic [7:0] q[$]);
      q.delete();
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
   endfunction

   initial begin
      vec_t tbl[7];
      logic [7:0] q[$];
      string foo;
      int bad_rtr, bad_rdy, sel, len;
      bit el;

      foo = "foobar";
      tbl[0] = '{0, "",       1'b0, 64'h811C9DC5};
      tbl[1] = '{0, "foobar", 1'b0, 64'hBF9CF968};
      tbl[2] = '{1, "foobar", 1'b1, 64'hBF9CF968};
      tbl[3] = '{2, "a",      1'b0, 64'hAF63DC4C8601EC8C};
      tbl[4] = '{2, "foobar", 1'b0, 64'h85944171F73967E8};
      tbl[5] = '{0, "a",      1'b0, 64'hE40C292C};
      tbl[6] = '{1, "foobar", 1'b0, 64'hBF9CF968};

      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 1'b0, 64'h0, 4'h0);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("rst_rh", get_rh(i), 64'h0);
         check("rst_rtr", {63'h0, get_rtr(i)}, 64'h0);
         check("rst_hrdy", {63'h0, get_rdy(i)}, 64'h0);
      end
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         str2q(tbl[i].msg, q);
         run_msg(tbl[i].sel, q, tbl[i].eof_last, 1'b0);
         check($sformatf("tbl%0d_rh", i), get_rh(tbl[i].sel), tbl[i].exp);
         check_cnt(tbl[i].sel, q.size());
      end

      // Spurious start after byte 3, then a 500-cycle source stall.
      begin_msg(0);
      for (int i = 0; i < 3; i++) beat(0, 64'(foo[i]), 1, 1'b0);
      wait_rtr(0);
      drive(0, 1'b1, 1'b0, 1'b0, 64'h0, 4'h0);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 1'b0, 64'h0, 4'h0);
      bad_rtr = 0;
      bad_rdy = 0;
      repeat (500) begin
         if (t0 !== 1'b1) bad_rtr++;
         if (y0 !== 1'b0) bad_rdy++;
         @(negedge clk);
      end
      check("stall_rtr", 64'(bad_rtr), 64'h0);
      check("stall_hrdy", 64'(bad_rdy), 64'h0);
      for (int i = 3; i < 6; i++) beat(0, 64'(foo[i]), 1, 1'b0);
      end_eof(0);
      check("stall_rh", get_rh(0), 64'hBF9CF968);

      // Reset while byte 2 is in PROC.
      begin_msg(0);
      beat(0, 64'h66, 1, 1'b0);
      wait_rtr(0);
      drive(0, 1'b0, 1'b1, 1'b0, 64'h6F, 4'h1);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 1'b0, 64'h0, 4'h0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_rtr", {63'h0, t0}, 64'h0);
      check("mid_rst_hrdy", {63'h0, y0}, 64'h0);
      check("mid_rst_rh", get_rh(0), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      str2q("a", q);
      run_msg(0, q, 1'b0, 1'b0);
      check("after_rst_rh", get_rh(0), 64'hE40C292C);

      // Random messages, random beat splits, clamped and empty beats.
      for (int it = 0; it < 30; it++) begin
         sel = $urandom_range(0, 2);
         len = $urandom_range(0, 9);
         q.delete();
         for (int j = 0; j < len; j++) q.push_back(8'($urandom));
         el = (len > 0) && ($urandom_range(0, 1) == 1);
         run_msg(sel, q, el, 1'b1);
         check($sformatf("rnd%0d_s%0d_rh", it, sel), get_rh(sel),
               ref_hash(hw(sel), q));
         check_cnt(sel, len);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
